uart_tx_ser: RTL and testbench
==============================

# uart_tx_ser

Transmit serializer for the UART datapath. It pops bytes from the TX FIFO and shifts each one out on the serial line as a standard asynchronous frame: start bit, data LSB-first, optional parity, then stop bit(s). It sits directly downstream of the TX FIFO storage. It reads that storage's asynchronous read data in the same cycle it issues the pop. The FIFO pointer logic advances on the pop.

## Interface
- DataWidth, 8, data bits per frame; must match the FIFO data width; 5..9
- ClksPerBit, 868, clock cycles per bit period (e.g. 100 MHz / 115200); must be ≥ 2
- Parity, 0, 0 = none, 1 = odd, 2 = even
- StopBits, 1, number of stop bits; 1 or 2

- i_clk  input  1  system clock; all logic on the rising edge
- i_rst_n  input  1  synchronous reset, active-low
- i_tx_en  input  1  transmit enable; gates new pops only
- i_fifo_empty  input  1  TX FIFO empty flag
- i_fifo_data  input  DataWidth  FIFO head word, combinationally valid while not empty
- o_fifo_pop  output  1  single-cycle pop strobe to the FIFO read pointer
- o_tx  output  1  serial line output; idle high
- o_busy  output  1  high from the cycle after a pop until the frame ends
- o_frame_done  output  1  single-cycle pulse in the last cycle of the final stop bit

## Operation
- States:
  - IDLE: o_tx = 1. If i_tx_en && !i_fifo_empty, assert o_fifo_pop, load i_fifo_data into the shift register, then go to START.
  - START: drive o_tx = 0 for ClksPerBit cycles.
  - DATA: DataWidth bits, LSB first, ClksPerBit cycles each.
  - PARITY: present only if Parity ≠ 0. Odd parity = ~^data; even parity = ^data.
  - STOP: drive o_tx = 1 for StopBits × ClksPerBit cycles.
- Baud counter:
  - Width is $clog2(ClksPerBit).
  - It is reloaded to ClksPerBit-1 on every bit entry and counts down.
  - A bit ends in the cycle the counter equals 0.
- Bit index: width $clog2(DataWidth); reset to 0 on entry to DATA.
- Stop-bit counter: counts the remaining stop bits when StopBits = 2.
- Back-to-back frames:
  - In the last cycle of the final stop bit, if i_tx_en && !i_fifo_empty, pop in that same cycle and go directly to START.
  - This leaves no idle cycle between frames.
  - Otherwise go to IDLE.
- Deasserting i_tx_en mid-frame has no effect on the frame in flight. It only suppresses the next pop.
- o_tx is registered and glitch-free; it is driven directly from a flop.
- Frame data is latched at pop. Changes on i_fifo_data after the pop are ignored.
- i_fifo_empty rising mid-frame has no effect.
- o_fifo_pop is never asserted while i_fifo_empty = 1.
- o_fifo_pop is never asserted twice within one frame.

## Timing
- Reset values:
  - State IDLE.
  - o_tx = 1, o_busy = 0, o_fifo_pop = 0, o_frame_done = 0.
  - Counters = 0.
- Reset asserted mid-frame: on the next edge o_tx = 1 and state is IDLE. No pop occurs in the reset cycle.
- Pop latency:
  - From IDLE, o_fifo_pop is a combinational function of the registered state and the inputs, in the same cycle the condition holds.
  - The start bit (o_tx = 0) appears on the following edge.
- Frame length: (1 + DataWidth + (Parity≠0) + StopBits) × ClksPerBit cycles, measured from the first start-bit cycle.
- o_busy:
  - Rises with the first start-bit cycle.
  - Falls after the final stop cycle when returning to IDLE.
  - Stays high across back-to-back frames.

## Test plan
- Reset, then FIFO empty for 100 cycles -> o_tx = 1, o_busy = 0, no pop.
- DataWidth = 8, ClksPerBit = 4, Parity = 0, StopBits = 1; push 0xA5:
  - One pop.
  - o_tx sequence per 4-cycle bit: 0, 1, 0, 1, 0, 0, 1, 0, 1, 1.
  - 40 cycles total, with o_frame_done at cycle 40.
- Parity = 2 (even), 0x07 -> parity bit 1. Parity = 1 (odd), 0x07 -> parity bit 0. Each frame is 44 cycles.
- Three words queued (0x00, 0xFF, 0x3C):
  - Three pops, spaced exactly 40 cycles apart.
  - No idle-high gap beyond the stop bit.
  - o_busy continuously high.
- i_tx_en dropped in the middle of frame 1 with 2 words queued -> frame 1 completes, no second pop, line idle high.
- i_rst_n asserted in the middle of the DATA state -> o_tx = 1 on the next cycle. After release with data queued, a new frame starts cleanly with a full start bit.

Source files
------------

// File: rtl/uart_tx_ser.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts them out as
// start / data (LSB first) / optional parity / stop frames on a registered line.
module uart_tx_ser #(
  parameter int DataWidth  = 8,
  parameter int ClksPerBit = 868,
  parameter int Parity     = 0,
  parameter int StopBits   = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_tx_en,
  input  logic                 i_fifo_empty,
  input  logic [DataWidth-1:0] i_fifo_data,
  output logic                 o_fifo_pop,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_frame_done
);

  localparam int BaudW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int IdxW  = (DataWidth > 1) ? $clog2(DataWidth) : 1;

  localparam logic [BaudW-1:0] BaudLoad = BaudW'(ClksPerBit - 1);
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(DataWidth - 1);
  localparam logic             StopLoad = (StopBits == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [BaudW-1:0]     baud_q, baud_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DataWidth-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 bit_end;
  logic                 can_pop;
  logic                 pop;
  logic                 done;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d is the line level for the cycle after this edge, so o_tx comes straight from a flop
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    done    = 1'b0;
    bit_end = (baud_q == '0);
    can_pop = i_tx_en && !i_fifo_empty;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (can_pop) begin
          pop     = 1'b1;
          shift_d = i_fifo_data;
          par_d   = (Parity == 1) ? ~^i_fifo_data : ^i_fifo_data;
          baud_d  = BaudLoad;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          baud_d  = BaudLoad;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          baud_d = BaudLoad;
          if (idx_q == LastIdx) begin
            if (Parity != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              stop_d  = StopLoad;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          stop_d  = StopLoad;
          baud_d  = BaudLoad;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          if (stop_q) begin
            stop_d = 1'b0;
            baud_d = BaudLoad;
          end else begin
            done = 1'b1;
            // Chain straight into the next start bit so frames run gap-free
            if (can_pop) begin
              pop     = 1'b1;
              shift_d = i_fifo_data;
              par_d   = (Parity == 1) ? ~^i_fifo_data : ^i_fifo_data;
              baud_d  = BaudLoad;
              state_d = S_START;
              tx_d    = 1'b0;
            end else begin
              baud_d  = '0;
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (!i_rst_n) begin
      pop  = 1'b0;
      done = 1'b0;
    end
  end

  assign o_fifo_pop   = pop;
  assign o_frame_done = done;
  assign o_tx         = tx_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_ser.sv
// Self-checking bench for uart_tx_ser: FIFO model plus scoreboard of expected
// serial frames, with extra instances covering even/odd parity and two stop bits.
module tb_uart_tx_ser;

  localparam int Cpb = 4;
  localparam int FrameLen = 10 * Cpb;

  logic       clk;
  logic       rst_n;
  logic       tx_en;
  logic       fifo_empty;
  logic [7:0] fifo_data;

  logic o_fifo_pop, o_tx, o_busy, o_frame_done;
  logic e_pop, e_tx, e_busy, e_done;
  logic o2_pop, o2_tx, o2_busy, o2_done;
  logic s_pop, s_tx, s_busy, s_done;

  uart_tx_ser #(.DataWidth(8), .ClksPerBit(Cpb), .Parity(0), .StopBits(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_en(tx_en), .i_fifo_empty(fifo_empty),
    .i_fifo_data(fifo_data), .o_fifo_pop(o_fifo_pop), .o_tx(o_tx),
    .o_busy(o_busy), .o_frame_done(o_frame_done));

  uart_tx_ser #(.DataWidth(8), .ClksPerBit(Cpb), .Parity(2), .StopBits(1)) u_even (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_en(tx_en), .i_fifo_empty(fifo_empty),
    .i_fifo_data(fifo_data), .o_fifo_pop(e_pop), .o_tx(e_tx),
    .o_busy(e_busy), .o_frame_done(e_done));

  uart_tx_ser #(.DataWidth(8), .ClksPerBit(Cpb), .Parity(1), .StopBits(1)) u_odd (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_en(tx_en), .i_fifo_empty(fifo_empty),
    .i_fifo_data(fifo_data), .o_fifo_pop(o2_pop), .o_tx(o2_tx),
    .o_busy(o2_busy), .o_frame_done(o2_done));

  uart_tx_ser #(.DataWidth(8), .ClksPerBit(Cpb), .Parity(0), .StopBits(2)) u_stop2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_en(tx_en), .i_fifo_empty(fifo_empty),
    .i_fifo_data(fifo_data), .o_fifo_pop(s_pop), .o_tx(s_tx),
    .o_busy(s_busy), .o_frame_done(s_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
  } vec_t;

  logic [7:0] fq[$];
  logic [9:0] sb[$];
  int         pop_cycs[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int pop_count = 0;
  int last_done = 0;
  int fpos     = 0;
  bit in_frame = 0;
  logic [9:0] cur_line;

  logic pop_s, tx_s, busy_s, done_s;
  logic pe_s, te_s, be_s, de_s;
  logic po_s, to_s, bo_s, do_s;
  logic ps_s, ts_s, bs_s, ds_s;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? 8'($urandom) : fq[0];
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic [9:0] line);
    fq.push_back(data);
    sb.push_back(line);
    refresh();
  endtask

  // One clock: sample at the falling edge, score the main instance, then model the FIFO pop
  task automatic tick();
    @(negedge clk);
    cyc++;
    pop_s = o_fifo_pop; tx_s = o_tx; busy_s = o_busy; done_s = o_frame_done;
    pe_s = e_pop;  te_s = e_tx;  be_s = e_busy;  de_s = e_done;
    po_s = o2_pop; to_s = o2_tx; bo_s = o2_busy; do_s = o2_done;
    ps_s = s_pop;  ts_s = s_tx;  bs_s = s_busy;  ds_s = s_done;
    if (!rst_n) begin
      in_frame = 0;
      checkOutput("rst_no_pop", pop_s, 1'b0);
    end else begin
      if (in_frame) begin
        checkOutput("frame_tx", tx_s, cur_line[fpos / Cpb]);
        checkOutput("frame_busy", busy_s, 1'b1);
        checkOutput("frame_done", done_s, (fpos == FrameLen - 1));
        if (done_s) last_done = cyc;
        fpos++;
        if (fpos == FrameLen) in_frame = 0;
      end else begin
        checkOutput("idle_tx", tx_s, 1'b1);
        checkOutput("idle_busy", busy_s, 1'b0);
        checkOutput("idle_done", done_s, 1'b0);
      end
      if (pop_s) begin
        checkOutput("pop_nonempty", fifo_empty, 1'b0);
        checkOutput("pop_once", in_frame, 1'b0);
        pop_count++;
        pop_cycs.push_back(cyc);
        if (sb.size() == 0) begin
          checkOutput("pop_expected", 1'b0, 1'b1);
        end else begin
          cur_line = sb.pop_front();
          in_frame = 1;
          fpos     = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    if (pop_s && fq.size() > 0) void'(fq.pop_front());
    refresh();
  endtask

  task automatic waitPop(input int limit);
    bit seen;
    seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      seen = pop_s;
    end
    if (!seen) checkOutput("pop_timeout", 1'b0, 1'b1);
  endtask

  vec_t vecs[4];
  logic [10:0] even_line, odd_line, stop2_line;
  int p0;

  initial begin
    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h01, 10'b1000000010};
    vecs[2] = '{8'h80, 10'b1100000000};
    vecs[3] = '{8'h5A, 10'b1010110100};
    even_line  = 11'b11000001110;
    odd_line   = 11'b10000001110;
    stop2_line = 11'b11000001110;

    rst_n = 1'b0;
    tx_en = 1'b0;
    refresh();
    repeat (3) tick();
    checkOutput("reset_tx", tx_s, 1'b1);
    checkOutput("reset_busy", busy_s, 1'b0);
    checkOutput("reset_done", done_s, 1'b0);

    rst_n = 1'b1;
    tx_en = 1'b1;
    p0 = pop_count;
    repeat (100) tick();
    checkOutput("idle_no_pop", pop_count - p0, 0);

    // 0x07 popped by all instances at once: even parity 1, odd parity 0, two stop bits
    applyStimulus(8'h07, 10'b1000001110);
    waitPop(5);
    checkOutput("even_pop", pe_s, 1'b1);
    checkOutput("odd_pop", po_s, 1'b1);
    checkOutput("stop2_pop", ps_s, 1'b1);
    for (int k = 0; k < 11 * Cpb; k++) begin
      tick();
      checkOutput("even_tx", te_s, even_line[k / Cpb]);
      checkOutput("even_done", de_s, (k == 11 * Cpb - 1));
      checkOutput("odd_tx", to_s, odd_line[k / Cpb]);
      checkOutput("odd_done", do_s, (k == 11 * Cpb - 1));
      checkOutput("stop2_tx", ts_s, stop2_line[k / Cpb]);
      checkOutput("stop2_done", ds_s, (k == 11 * Cpb - 1));
      checkOutput("stop2_busy", bs_s, 1'b1);
    end
    tick();
    checkOutput("even_busy_fall", be_s, 1'b0);
    checkOutput("odd_busy_fall", bo_s, 1'b0);
    checkOutput("stop2_busy_fall", bs_s, 1'b0);

    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].data, vecs[v].line);
      waitPop(5);
      repeat (FrameLen) tick();
      checkOutput("frame_len", last_done - pop_cycs[pop_cycs.size() - 1], FrameLen);
      tick();
      checkOutput("busy_fall", busy_s, 1'b0);
    end

    p0 = pop_count;
    applyStimulus(8'h00, 10'b1000000000);
    applyStimulus(8'hFF, 10'b1111111110);
    applyStimulus(8'h3C, 10'b1001111000);
    waitPop(5);
    repeat (3 * FrameLen + 2) tick();
    checkOutput("b2b_pops", pop_count - p0, 3);
    checkOutput("b2b_gap1", pop_cycs[pop_cycs.size() - 2] - pop_cycs[pop_cycs.size() - 3], FrameLen);
    checkOutput("b2b_gap2", pop_cycs[pop_cycs.size() - 1] - pop_cycs[pop_cycs.size() - 2], FrameLen);

    p0 = pop_count;
    applyStimulus(8'h55, 10'b1010101010);
    applyStimulus(8'hAA, 10'b1101010100);
    waitPop(5);
    repeat (20) tick();
    tx_en = 1'b0;
    repeat (30) tick();
    checkOutput("en_drop_pops", pop_count - p0, 1);
    checkOutput("en_drop_idle", tx_s, 1'b1);
    checkOutput("en_drop_busy", busy_s, 1'b0);
    tx_en = 1'b1;
    waitPop(5);
    repeat (FrameLen + 1) tick();
    checkOutput("en_resume_pops", pop_count - p0, 2);

    applyStimulus(8'hC3, 10'b1110000110);
    applyStimulus(8'h96, 10'b1100101100);
    waitPop(5);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    tick();
    checkOutput("rst_mid_tx", tx_s, 1'b1);
    checkOutput("rst_mid_busy", busy_s, 1'b0);
    rst_n = 1'b1;
    waitPop(5);
    repeat (FrameLen) tick();
    checkOutput("rst_recover_len", last_done - pop_cycs[pop_cycs.size() - 1], FrameLen);
    tick();
    checkOutput("rst_recover_idle", tx_s, 1'b1);
    checkOutput("fifo_drained", fq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
